// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    // First fetch address after reset unless the instance overrides it.
    localparam logic [ADDR_W-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // Two-bit state encoding; 2'b11 is unused and recovers to FETCH.
    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_DISCARD = 2'b01,
        ST_HOLD    = 2'b10
    } fetch_state_t;

    // Force a byte address onto a word boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-pc select: redirect > +4 > hold.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] pc_next;

    // Sequential increment; wraps from 32'hFFFF_FFFC to zero silently.
    assign pc_plus4 = pc + ADDR_W'(4);

    // Pick the next pc; a redirect always beats the sequential step.
    always_comb begin
        pc_next = pc;
        if (redirect_en) begin
            pc_next = word_align(redirect_pc);
        end else if (advance) begin
            pc_next = pc_plus4;
        end
    end

    // PC state; reset loads the (aligned) reset vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= word_align(RESET_VECTOR);
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples pre-edge values, independent of block ordering.
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests words from instruction memory, holds the
// latched instruction for decode, and handles redirects at any point of a
// memory transaction without ever withdrawing an issued request.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc4
);

    fetch_state_t       state;
    fetch_state_t       state_next;
    logic               started;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  discard_addr;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  ir_pc;
    logic               pc_redirect;
    logic               pc_advance;
    logic               capture;
    logic               save_addr;

    fetch_pc_reg #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc (
        .clk          (clk),
        .reset        (reset),
        .redirect_en  (pc_redirect),
        .redirect_pc  (redirect_pc),
        .advance      (pc_advance),
        .pc           (pc)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath controls; nothing moves until the first edge
    // after reset release, so an early ack cannot be mistaken for data.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and a latch is never inferred.
        state_next  = state;
        pc_redirect = 1'b0;
        pc_advance  = 1'b0;
        capture     = 1'b0;
        save_addr   = 1'b0;
        if (started) begin
            case (state)
                ST_FETCH: begin
                    if (redirect_valid) begin
                        // Data arriving with a redirect is stale; drop it.
                        pc_redirect = 1'b1;
                        if (!imem_ack) begin
                            save_addr  = 1'b1;
                            state_next = ST_DISCARD;
                        end
                    end else if (imem_ack) begin
                        capture    = 1'b1;
                        pc_advance = 1'b1;
                        state_next = ST_HOLD;
                    end
                end
                ST_DISCARD: begin
                    // Keep the old request alive; the latest redirect wins.
                    pc_redirect = redirect_valid;
                    if (imem_ack) begin
                        state_next = ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        pc_redirect = 1'b1;
                        state_next  = ST_FETCH;
                    end else if (if_ready) begin
                        state_next = ST_FETCH;
                    end
                end
                default: begin
                    state_next = ST_FETCH;
                end
            endcase
        end
    end

    // Start flag, instruction register and the address of an abandoned request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: every flop here gets an explicit reset value so the
            // interface is defined on the very first cycle after release.
            started      <= 1'b0;
            ir           <= '0;
            ir_pc        <= '0;
            discard_addr <= '0;
        end else begin
            started <= 1'b1;
            if (capture) begin
                ir    <= imem_rdata;
                ir_pc <= pc;
            end
            if (save_addr) begin
                discard_addr <= pc;
            end
        end
    end

    // Outputs decode registered state only; if_pc4 alone is arithmetic on if_pc.
    assign imem_req  = started && ((state == ST_FETCH) || (state == ST_DISCARD));
    assign imem_addr = (state == ST_DISCARD) ? discard_addr : pc;
    assign if_valid  = (state == ST_HOLD);
    assign if_instr  = ir;
    assign if_pc     = ir_pc;
    assign if_pc4    = ir_pc + ADDR_W'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, plain fetch, decode stall, redirects
// in each state, pc wrap and reset in the middle of a request.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4)
    );

    // Advance one cycle and land just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 00000000", if_instr); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 00000000", if_pc); end
        checks++; if (if_pc4 !== 32'h4) begin errors++; $display("FAIL rst_pc4: got %h want 00000004", if_pc4); end
        step(); step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req_held: got %b want 0", imem_req); end
        reset = 1'b1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rel_req: got %b want 0", imem_req); end
        // A stray ack in the first cycle after release must be ignored.
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h want 00000000", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL early_ack: got %b want 0", if_valid); end
    endtask

    task automatic test_first_fetch();
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wait_addr: got %b/%h want 1/00000000", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h2402_0005;
        step();
        imem_ack = 1'b0;
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL ff_valid: got %b want 1", if_valid); end
        checks++; if (if_instr !== 32'h2402_0005) begin errors++; $display("FAIL ff_instr: got %h want 24020005", if_instr); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL ff_pc: got %h want 00000000", if_pc); end
        checks++; if (if_pc4 !== 32'h4) begin errors++; $display("FAIL ff_pc4: got %h want 00000004", if_pc4); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ff_req: got %b want 0", imem_req); end
    endtask

    task automatic test_hold_stall();
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (if_valid !== 1'b1 || if_instr !== 32'h2402_0005 || imem_req !== 1'b0) begin
                errors++; $display("FAIL stall_%0d: got v=%b i=%h r=%b want v=1 i=24020005 r=0", i, if_valid, if_instr, imem_req);
            end
        end
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL handoff_valid: got %b want 0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL next_addr: got %b/%h want 1/00000004", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        step();
        imem_ack = 1'b0;
        checks++; if (if_pc !== 32'h4 || if_instr !== 32'h1111_1111) begin errors++; $display("FAIL second: got %h/%h want 00000004/11111111", if_pc, if_instr); end
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL addr8: got %h want 00000008", imem_addr); end
    endtask

    task automatic test_redirect_wait();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL disc_addr: got %b/%h want 1/00000008", imem_req, imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL disc_valid: got %b want 0", if_valid); end
        step();
        checks++; if (imem_addr !== 32'h8 || if_valid !== 1'b0) begin errors++; $display("FAIL disc_hold: got %h/%b want 00000008/0", imem_addr, if_valid); end
        imem_ack = 1'b1; imem_rdata = 32'hBADB_AD01;
        step();
        imem_ack = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL drop_valid: got %b want 0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr: got %b/%h want 1/00000040", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
        step();
        imem_ack = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h2222_2222) begin
            errors++; $display("FAIL redir_data: got %b/%h/%h want 1/00000040/22222222", if_valid, if_pc, if_instr);
        end
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        checks++; if (imem_addr !== 32'h44) begin errors++; $display("FAIL addr44: got %h want 00000044", imem_addr); end
    endtask

    task automatic test_redirect_ack();
        imem_ack = 1'b1; imem_rdata = 32'hBADB_AD02;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
        step();
        imem_ack = 1'b0; redirect_valid = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL coinc_valid: got %b want 0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL coinc_addr: got %b/%h want 1/00000040", imem_req, imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        step();
        redirect_pc = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'h40 || if_valid !== 1'b0) begin errors++; $display("FAIL double_hold: got %h/%b want 00000040/0", imem_addr, if_valid); end
        imem_ack = 1'b1; imem_rdata = 32'hBADB_AD03;
        step();
        imem_ack = 1'b0;
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL last_wins: got %h want 00000200", imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
        step();
        imem_ack = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin errors++; $display("FAIL pc200: got %b/%h want 1/00000200", if_valid, if_pc); end
        // Redirect together with a handoff in HOLD.
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        if_ready = 1'b0; redirect_valid = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL hold_redir_valid: got %b want 0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL hold_redir_addr: got %b/%h want 1/fffffffc", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
        step();
        imem_ack = 1'b0;
        checks++; if (if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h want fffffffc", if_pc); end
        checks++; if (if_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want 00000000", if_pc4); end
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %b/%h want 1/00000000", imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid();
        imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        step();
        imem_ack = 1'b0; if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin errors++; $display("FAIL pre_rst: got %b/%h want 1/00000004", imem_req, imem_addr); end
        #3;
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %b want 0", imem_req); end
        checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0) begin errors++; $display("FAIL mid_rst_state: got %b/%h want 0/00000000", if_valid, if_pc); end
        step();
        reset = 1'b1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_rel_req: got %b want 0", imem_req); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_restart: got %b/%h want 1/00000000", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a hung simulation.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be 00.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; reset==0 clears state immediately.
REQ-004 imem_req  out  1  fetch request to instruction memory.
REQ-005 imem_addr  out  32  byte address of the requested word.
REQ-006 imem_ack  in  1  one-cycle pulse; imem_rdata is valid in that cycle.
REQ-007 imem_rdata  in  32  instruction word.
REQ-008 redirect_valid  in  1  one-cycle pulse; change fetch stream (branch/jump/jr).
REQ-009 redirect_pc  in  32  new fetch address; bits [1:0] ignored and treated as 00.
REQ-010 if_valid  out  1  instruction available to decode.
REQ-011 if_ready  in  1  decode accepts; handoff when if_valid&&if_ready.
REQ-012 if_instr  out  32  latched instruction (IR).
REQ-013 if_pc  out  32  address of if_instr.
REQ-014 if_pc4  out  32  if_pc+4, modulo 2^32.

Function
REQ-015 FSM states: FETCH, DISCARD, HOLD.
REQ-016 FETCH: imem_req=1, imem_addr=pc; on imem_ack latch IR=imem_rdata, if_pc=pc, pc<=pc+4, go HOLD.
REQ-017 HOLD: if_valid=1, imem_req=0; on if_ready go FETCH; if_instr/if_pc stable until handoff.
REQ-018 imem_req and imem_addr SHALL remain stable from assertion until imem_ack; a request is never withdrawn.
REQ-019 redirect in FETCH without ack: pc<=redirect_pc, go DISCARD; imem_addr keeps the old address.
REQ-020 DISCARD: imem_req=1 on the old address; on imem_ack drop the data, go FETCH at the redirected pc; if_valid=0.
REQ-021 redirect in the same cycle as imem_ack in FETCH: data dropped, pc<=redirect_pc, stay in FETCH.
REQ-022 redirect in HOLD: if_valid falls next cycle, pc<=redirect_pc, go FETCH; a handoff with if_ready in the same cycle still counts as one delivered instruction.
REQ-023 redirect in DISCARD: pc<=latest redirect_pc; the last redirect wins.
REQ-024 pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 without a flag.
REQ-025 Fetch-to-valid latency: if_valid rises on the edge after the imem_ack cycle; the next imem_req rises on the edge after handoff.

Reset
REQ-026 reset==0: state=FETCH, pc=RESET_VECTOR, IR=0, if_pc=0, if_valid=0.
REQ-027 imem_req=0 while reset==0; FETCH SHALL begin on the first edge after deassertion.
REQ-028 Reset mid-transaction drops any outstanding request; an imem_ack arriving in the first cycle after reset SHALL be ignored.

Structure
REQ-029 Shared package fetch_pkg SHALL hold the state encoding (2 bits), INSTR_W=32, ADDR_W=32, and the default RESET_VECTOR.
REQ-030 One sub-module, fetch_pc_reg, SHALL hold the pc register with next-pc select (redirect > +4 > hold) and async active-low reset.
REQ-031 if_pc4 SHALL be combinational from if_pc; no other outputs are combinational from inputs.

Verification
REQ-032 Reset release, imem_ack after 2 cycles with 32'h2402_0005 -> imem_addr=0, then if_valid=1, if_instr=32'h2402_0005, if_pc=0, if_pc4=4.
REQ-033 if_ready held low 5 cycles in HOLD -> if_valid/if_instr stable, imem_req=0; if_ready=1 -> next imem_addr=4.
REQ-034 redirect_pc=32'h0000_0040 while waiting on addr 8 -> addr 8 held until ack, data dropped, next imem_addr=0x40, no if_valid in between.
REQ-035 redirect coincident with ack -> if_valid stays 0, next imem_addr=redirect_pc; redirect_pc=32'h0000_0043 -> imem_addr=0x40.
REQ-036 pc=32'hFFFF_FFFC fetched -> if_pc4=0, next imem_addr=0; reset asserted during WAIT -> imem_req=0 at once, first fetch at RESET_VECTOR.
